// File: rtl/tt_ctrl_sel.sv
// Design-select controller: synchronises the pad select controls,
// keeps the selected design address and a settle-gated enable.
module tt_ctrl_sel #(
  parameter int ADDR_W        = 10,
  parameter int MAX_ADDR      = 1023,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_rst_n_i,
  input  logic              sel_inc_i,
  input  logic              ena_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              ena_o,
  output logic              busy_o
);

  localparam int CNT_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX =
    ADDR_W'(MAX_ADDR);

  typedef enum logic {
    IDLE,
    SETTLE
  } state_e;

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] inc_sync_q;
  logic [SYNC_STAGES-1:0] ena_sync_q;
  logic                   sel_rst_n_s;
  logic                   inc_s;
  logic                   ena_s;
  logic                   inc_q;
  logic                   inc_ev;
  logic                   evt;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ena_q, ena_d;
  logic              busy_q, busy_d;

  assign sel_rst_n_s = rst_sync_q[SYNC_STAGES-1];
  assign inc_s       = inc_sync_q[SYNC_STAGES-1];
  assign ena_s       = ena_sync_q[SYNC_STAGES-1];

  // Clear masks the increment so a simultaneous rise is dropped.
  assign inc_ev = inc_s & ~inc_q & sel_rst_n_s;
  assign evt    = inc_ev | ~sel_rst_n_s;

  // Pad synchronisers and increment edge register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_sync_q <= '0;
      inc_sync_q <= '0;
      ena_sync_q <= '0;
      inc_q      <= 1'b0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], sel_rst_n_i};
      inc_sync_q <= {inc_sync_q[SYNC_STAGES-2:0], sel_inc_i};
      ena_sync_q <= {ena_sync_q[SYNC_STAGES-2:0], ena_i};
      inc_q      <= inc_s;
    end
  end

  // Address update: clear wins, then increment with wrap.
  always_comb begin
    addr_d = addr_q;
    if (!sel_rst_n_s) begin
      addr_d = '0;
    end else if (inc_ev) begin
      if (addr_q == ADDR_MAX) begin
        addr_d = '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  // Settle FSM: any event (re)opens the settle window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ena_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (evt) begin
          state_d = SETTLE;
          cnt_d   = CNT_LOAD;
        end else begin
          ena_d = ena_s;
        end
      end
      SETTLE: begin
        if (evt) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          ena_d   = ena_s;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = CNT_LOAD;
      end
    endcase
    busy_d = (state_d == SETTLE);
  end

  // Registered state and outputs driving the spine buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SETTLE;
      cnt_q   <= CNT_LOAD;
      addr_q  <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
    end
  end

  assign addr_o = addr_q;
  assign ena_o  = ena_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_tt_ctrl_sel.sv
// Scoreboard bench for tt_ctrl_sel: stimulus queues expected
// output changes, a monitor pops one on every observed change.
module tb_tt_ctrl_sel;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_rst_n_i;
  logic       sel_inc_i;
  logic       ena_i;
  logic [9:0] addr_o;
  logic       ena_o;
  logic       busy_o;

  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic       ena;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   cyc  = 0;
  bit   done = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   viol   = 0;

  tt_ctrl_sel #(
    .ADDR_W       (10),
    .MAX_ADDR     (5),
    .SETTLE_CYCLES(4),
    .SYNC_STAGES  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel_rst_n_i(sel_rst_n_i),
    .sel_inc_i  (sel_inc_i),
    .ena_i      (ena_i),
    .addr_o     (addr_o),
    .ena_o      (ena_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int a,
                      input logic e, input logic b);
    exp_t x;
    x.cyc  = c;
    x.addr = 10'(a);
    x.ena  = e;
    x.busy = b;
    q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One increment from IDLE: address at +3, enable back at +7.
  task automatic inc_pulse(input int hold, input int a);
    int c;
    c = cyc;
    push(c + 3, a, 1'b0, 1'b1);
    push(c + 7, a, 1'b1, 1'b0);
    sel_inc_i = 1'b1;
    tick(hold);
    sel_inc_i = 1'b0;
    tick(6);
  endtask

  // Stimulus
  initial begin
    int c;
    rst         = 1'b1;
    sel_rst_n_i = 1'b1;
    sel_inc_i   = 1'b0;
    ena_i       = 1'b1;
    push(1, 0, 1'b0, 1'b1);
    tick(3);
    rst = 1'b0;
    push(9, 0, 1'b1, 1'b0);
    tick(8);

    inc_pulse(10, 1);
    inc_pulse(2, 2);
    inc_pulse(2, 3);
    inc_pulse(2, 4);
    inc_pulse(2, 5);
    inc_pulse(2, 0);

    c = cyc;
    push(c + 3, 1, 1'b0, 1'b1);
    push(c + 5, 2, 1'b0, 1'b1);
    push(c + 9, 2, 1'b1, 1'b0);
    sel_inc_i = 1'b1;
    tick(1);
    sel_inc_i = 1'b0;
    tick(1);
    sel_inc_i = 1'b1;
    tick(1);
    sel_inc_i = 1'b0;
    tick(8);

    inc_pulse(2, 3);

    c = cyc;
    push(c + 3, 0, 1'b0, 1'b1);
    push(c + 11, 0, 1'b1, 1'b0);
    sel_rst_n_i = 1'b0;
    sel_inc_i   = 1'b1;
    tick(5);
    sel_rst_n_i = 1'b1;
    tick(7);
    sel_inc_i = 1'b0;
    tick(4);

    c = cyc;
    push(c + 3, 0, 1'b0, 1'b0);
    push(c + 7, 0, 1'b1, 1'b0);
    ena_i = 1'b0;
    tick(4);
    ena_i = 1'b1;
    tick(6);

    c = cyc;
    push(c + 3, 1, 1'b0, 1'b1);
    push(c + 5, 0, 1'b0, 1'b1);
    push(c + 12, 0, 1'b1, 1'b0);
    sel_inc_i = 1'b1;
    tick(2);
    sel_inc_i = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    done = 1'b1;
  end

  // Monitor: every change of the output bundle is a response.
  initial begin
    logic [11:0] prev;
    logic [11:0] cur;
    exp_t        e;
    prev = 'x;
    forever begin
      @(negedge clk);
      if (ena_o && busy_o) viol++;
      cur = {addr_o, ena_o, busy_o};
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_change cyc=%0d addr=%0d ena=%b busy=%b",
                   cyc, addr_o, ena_o, busy_o);
        end else begin
          e = q.pop_front();
          if (cyc == e.cyc && addr_o === e.addr &&
              ena_o === e.ena && busy_o === e.busy) begin
            passed++;
          end else begin
            $display("FAIL change got cyc=%0d addr=%0d ena=%b busy=%b want cyc=%0d addr=%0d ena=%b busy=%b",
                     cyc, addr_o, ena_o, busy_o,
                     e.cyc, e.addr, e.ena, e.busy);
          end
        end
      end
      prev = cur;
      if (done || cyc > 5000) begin
        checks++;
        if (!done) begin
          $display("FAIL timeout cyc=%0d want done", cyc);
        end else if (q.size() != 0) begin
          $display("FAIL pending got %0d outstanding want 0",
                   q.size());
        end else begin
          passed++;
        end
        checks++;
        if (viol != 0) begin
          $display("FAIL ena_busy_overlap got %0d cycles want 0",
                   viol);
        end else begin
          passed++;
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
      end
    end
  end

endmodule
